// File: rtl/exp_series_ctrl_if.sv
// -----------------------------------------------------------------------------
// exp_series_ctrl_if
// Purpose : Bundles the host handshake (start/abort/busy/done) and the
//           accelerator datapath/ROM strobes of the Taylor-series controller.
// Signals : start, abort      host -> controller run request / synchronous abort
//           rom_adr[ADR_W]    controller -> coefficient ROM address
//           x_ld, init        controller -> datapath operand capture / 1.0 preload
//           term_en, acc_en   controller -> datapath term multiply / accumulate
//           busy, done        controller -> host status / one-cycle completion
// Modports: master = host side (drives start/abort, observes everything else)
//           slave  = controller side
// -----------------------------------------------------------------------------
interface exp_series_ctrl_if #(
    parameter int ADR_W = 4
);
    logic             start;
    logic             abort;
    logic [ADR_W-1:0] rom_adr;
    logic             x_ld;
    logic             init;
    logic             term_en;
    logic             acc_en;
    logic             busy;
    logic             done;

    modport master (
        output start, abort,
        input  rom_adr, x_ld, init, term_en, acc_en, busy, done
    );

    modport slave (
        input  start, abort,
        output rom_adr, x_ld, init, term_en, acc_en, busy, done
    );
endinterface

// File: rtl/exp_series_ctrl.sv
// -----------------------------------------------------------------------------
// exp_series_ctrl
// Purpose : Sequencer for the Taylor-series e^x accelerator
//           (e^x ~ sum_{k=0..N} x^k/k!). After a LOAD cycle that captures x and
//           presets term = acc = 1.0, each of N_TERMS iterations spends one MULT
//           cycle (term <= term*x*coef[k]) and one ADD cycle (acc <= acc+term),
//           with the reciprocal-coefficient ROM addressed by the term counter.
// Params  : N_TERMS  coefficients applied per run, 1..16, N_TERMS <= 2**ADR_W
//           ADR_W    ROM address width
// Ports   : clk      rising-edge clock
//           rst      asynchronous reset, active-low
//           bus      exp_series_ctrl_if.slave (start/abort in; rom_adr,
//                    x_ld, init, term_en, acc_en, busy, done out)
// -----------------------------------------------------------------------------
module exp_series_ctrl #(
    parameter int N_TERMS = 12,
    parameter int ADR_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    exp_series_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MULT = 3'd2,
        ADD  = 3'd3,
        DONE = 3'd4
    } state_e;

    localparam logic [ADR_W-1:0] CNT_LAST = ADR_W'(N_TERMS - 1);

    state_e           state_q, state_d;
    logic [ADR_W-1:0] cnt_q, cnt_d;

    // Output strobes are registered copies of the next-state decode, so every
    // output is a pure function of the current state and never of an input.
    logic x_ld_q, init_q, term_en_q, acc_en_q, busy_q, done_q;

    // Next-state logic.
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.abort) begin
            // Abort wins over everything, including a simultaneous start.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: if (bus.start) state_d = LOAD;
                LOAD: begin
                    cnt_d   = '0;
                    state_d = MULT;
                end
                MULT: state_d = ADD;
                ADD: begin
                    // cnt stays at the last index when the run completes; it is
                    // only cleared again by LOAD, abort or reset.
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = MULT;
                    end
                end
                DONE: state_d = bus.start ? LOAD : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            x_ld_q    <= 1'b0;
            init_q    <= 1'b0;
            term_en_q <= 1'b0;
            acc_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_ld_q    <= (state_d == LOAD);
            init_q    <= (state_d == LOAD);
            term_en_q <= (state_d == MULT);
            acc_en_q  <= (state_d == ADD);
            busy_q    <= (state_d == LOAD) || (state_d == MULT) || (state_d == ADD);
            done_q    <= (state_d == DONE);
        end
    end

    assign bus.rom_adr = cnt_q;
    assign bus.x_ld    = x_ld_q;
    assign bus.init    = init_q;
    assign bus.term_en = term_en_q;
    assign bus.acc_en  = acc_en_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_exp_series_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exp_series_ctrl
// Purpose : Directed self-checking bench for exp_series_ctrl. Two instances:
//           u_dut_a with N_TERMS=12 and u_dut_b with N_TERMS=1. A small Q8.8
//           datapath model follows u_dut_a's strobes to confirm the sequencing
//           produces e^0.5.
// Cycle n : the clock period following the n-th rising edge after start was
//           sampled (cycle 1 = LOAD, cycle 26 = DONE for N_TERMS=12).
// -----------------------------------------------------------------------------
module tb_exp_series_ctrl;

    logic clk;
    logic rst;

    exp_series_ctrl_if #(.ADR_W(4)) bus_a ();
    exp_series_ctrl_if #(.ADR_W(4)) bus_b ();

    exp_series_ctrl #(.N_TERMS(12), .ADR_W(4)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    exp_series_ctrl #(.N_TERMS(1), .ADR_W(4)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Q0.8 reciprocal coefficients, rounded; 1/1 saturates to 255/256.
    function automatic int coef(input int k);
        int v;
        v = (256 + (k + 1) / 2) / (k + 1);
        return (v > 255) ? 255 : v;
    endfunction

    // Datapath model and pulse counters for u_dut_a, sampled mid-cycle.
    int m_term = 0;
    int m_acc  = 0;
    int m_x    = 0;
    int term_cnt = 0;
    int acc_cnt  = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        check("strobe_onehot",
              ((((bus_a.x_ld | bus_a.init) ? 1 : 0) + (bus_a.term_en ? 1 : 0) +
                (bus_a.acc_en ? 1 : 0) + (bus_a.done ? 1 : 0)) <= 1) ? 1 : 0, 1);
        if (bus_a.busy)
            check("adr_range", (bus_a.rom_adr <= 4'd11) ? 1 : 0, 1);
        if (bus_a.init) begin
            m_term = 256;
            m_acc  = 256;
            m_x    = 128;                  // x = 0.5 in Q8.8
        end
        if (bus_a.term_en) begin
            m_term = (m_term * m_x * coef(int'(bus_a.rom_adr)) + 32768) >>> 16;
            term_cnt++;
        end
        if (bus_a.acc_en) begin
            m_acc = m_acc + m_term;
            acc_cnt++;
        end
        if (bus_a.done) done_cnt++;
    end

    // Expected outputs of u_dut_a in cycle c (1..26) of a nominal run.
    task automatic check_run_cycle(input int c);
        check($sformatf("busy@%0d", c),    bus_a.busy,    (c >= 1 && c <= 25) ? 1 : 0);
        check($sformatf("done@%0d", c),    bus_a.done,    (c == 26) ? 1 : 0);
        check($sformatf("x_ld@%0d", c),    bus_a.x_ld,    (c == 1) ? 1 : 0);
        check($sformatf("init@%0d", c),    bus_a.init,    (c == 1) ? 1 : 0);
        check($sformatf("term_en@%0d", c), bus_a.term_en, (c >= 2 && c <= 25 && c % 2 == 0) ? 1 : 0);
        check($sformatf("acc_en@%0d", c),  bus_a.acc_en,  (c >= 3 && c <= 25 && c % 2 == 1) ? 1 : 0);
        if (c >= 2 && c <= 25)
            check($sformatf("rom_adr@%0d", c), bus_a.rom_adr, (c - 2) / 2);
    endtask

    initial begin
        rst         = 1'b0;
        bus_a.start = 1'b0;
        bus_a.abort = 1'b0;
        bus_b.start = 1'b0;
        bus_b.abort = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();

        // ---- reset state ----
        check("rst_busy",    bus_a.busy,    0);
        check("rst_done",    bus_a.done,    0);
        check("rst_x_ld",    bus_a.x_ld,    0);
        check("rst_term_en", bus_a.term_en, 0);
        check("rst_acc_en",  bus_a.acc_en,  0);
        check("rst_rom_adr", bus_a.rom_adr, 0);

        // ---- nominal N=12 run, single-cycle start ----
        term_cnt = 0; acc_cnt = 0; done_cnt = 0;
        bus_a.start = 1'b1;
        step();
        bus_a.start = 1'b0;
        for (int c = 1; c <= 26; c++) begin
            check_run_cycle(c);
            step();
        end
        check("nom_idle_busy", bus_a.busy, 0);
        check("nom_idle_done", bus_a.done, 0);
        check("nom_cnt_held",  bus_a.rom_adr, 11);
        check("nom_term_cnt",  term_cnt, 12);
        check("nom_acc_cnt",   acc_cnt, 12);
        check("nom_done_cnt",  done_cnt, 1);
        // e^0.5 = 1.6487 -> 422.07 in Q8.8; accept +/-2 LSB.
        check("dp_acc_tol", (m_acc >= 420 && m_acc <= 424) ? 1 : 0, 1);

        // ---- start held high: ignored while busy, restarts from DONE ----
        done_cnt = 0;
        bus_a.start = 1'b1;
        step();
        for (int run = 0; run < 2; run++) begin
            for (int c = 1; c <= 26; c++) begin
                if (run == 1 && c == 5) bus_a.start = 1'b0;
                check_run_cycle(c);
                step();
            end
        end
        check("b2b_idle_busy", bus_a.busy, 0);
        check("b2b_done_cnt",  done_cnt, 2);

        // ---- abort in cycle 10 (cnt=4) ----
        done_cnt = 0;
        bus_a.start = 1'b1;
        step();
        bus_a.start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            check_run_cycle(c);
            if (c < 10) step();
        end
        bus_a.abort = 1'b1;
        step();
        bus_a.abort = 1'b0;
        check("abort_busy",    bus_a.busy,    0);
        check("abort_rom_adr", bus_a.rom_adr, 0);
        check("abort_done",    bus_a.done,    0);
        check("abort_term_en", bus_a.term_en, 0);
        for (int i = 0; i < 20; i++) step();
        check("abort_no_done", done_cnt, 0);
        check("abort_stays_idle", bus_a.busy, 0);

        // ---- start and abort together in IDLE ----
        bus_a.start = 1'b1;
        bus_a.abort = 1'b1;
        step();
        bus_a.start = 1'b0;
        bus_a.abort = 1'b0;
        check("sa_busy", bus_a.busy, 0);
        check("sa_x_ld", bus_a.x_ld, 0);
        step();
        check("sa_busy_later", bus_a.busy, 0);

        // ---- asynchronous reset mid-MULT ----
        done_cnt = 0;
        bus_a.start = 1'b1;
        step();
        bus_a.start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check_run_cycle(c);
            if (c < 4) step();
        end
        #2 rst = 1'b0;
        #1;
        check("arst_busy",    bus_a.busy,    0);
        check("arst_term_en", bus_a.term_en, 0);
        check("arst_rom_adr", bus_a.rom_adr, 0);
        check("arst_done",    bus_a.done,    0);
        step();
        rst = 1'b1;
        step();
        check("arst_rel_busy",    bus_a.busy,    0);
        check("arst_rel_rom_adr", bus_a.rom_adr, 0);
        check("arst_no_done",     done_cnt, 0);

        // ---- N_TERMS=1 instance ----
        bus_b.start = 1'b1;
        step();
        bus_b.start = 1'b0;
        check("n1_c1_x_ld",    bus_b.x_ld,    1);
        check("n1_c1_busy",    bus_b.busy,    1);
        step();
        check("n1_c2_term_en", bus_b.term_en, 1);
        check("n1_c2_rom_adr", bus_b.rom_adr, 0);
        step();
        check("n1_c3_acc_en",  bus_b.acc_en,  1);
        check("n1_c3_done",    bus_b.done,    0);
        step();
        check("n1_c4_done",    bus_b.done,    1);
        check("n1_c4_busy",    bus_b.busy,    0);
        step();
        check("n1_c5_done",    bus_b.done,    0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
